// File: rtl/reset_sequencer.sv
// Ordered release of peripheral, memory and CPU reset domains,
// with a CPU-requested soft reset that re-sequences memory and core.
module reset_sequencer #(
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    input  logic       mem_init_done,
    output logic       periph_rst,
    output logic       mem_rst,
    output logic       cpu_rst,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam int MAX_COUNT = (STRETCH_CYCLES > STAGE_GAP) ?
                               STRETCH_CYCLES : STAGE_GAP;
    localparam int CW = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] ONE          = CW'(1);

    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [2:0] {
        HOLD,
        STRETCH,
        PGAP,
        WAIT_MEM,
        RUN,
        SOFT
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    // Sequencer: state, shared stage counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            count      <= '0;
            periph_rst <= 1'b1;
            mem_rst    <= 1'b1;
            cpu_rst    <= 1'b1;
            rst_done   <= 1'b0;
            rst_cause  <= CAUSE_EXT;
        end else begin
            case (state)
                HOLD: begin
                    state <= STRETCH;
                    count <= '0;
                end
                STRETCH: begin
                    if (count == STRETCH_LAST) begin
                        state      <= PGAP;
                        count      <= '0;
                        periph_rst <= 1'b0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                PGAP: begin
                    if (count == GAP_LAST) begin
                        state   <= WAIT_MEM;
                        count   <= '0;
                        mem_rst <= 1'b0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_init_done) begin
                        state    <= RUN;
                        count    <= '0;
                        cpu_rst  <= 1'b0;
                        rst_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        state     <= SOFT;
                        count     <= '0;
                        mem_rst   <= 1'b1;
                        cpu_rst   <= 1'b1;
                        rst_done  <= 1'b0;
                        rst_cause <= CAUSE_SOFT;
                    end
                end
                SOFT: begin
                    if (count == GAP_LAST) begin
                        state   <= WAIT_MEM;
                        count   <= '0;
                        mem_rst <= 1'b0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state      <= HOLD;
                    count      <= '0;
                    periph_rst <= 1'b1;
                    mem_rst    <= 1'b1;
                    cpu_rst    <= 1'b1;
                    rst_done   <= 1'b0;
                    rst_cause  <= CAUSE_EXT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, corner sequences and
// randomized stimulus against an edge-timestamp reference model.
module tb_reset_sequencer;

    localparam int SC = 4;
    localparam int SG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       mem_init_done = 1'b0;
    logic       periph_rst;
    logic       mem_rst;
    logic       cpu_rst;
    logic       rst_done;
    logic [1:0] rst_cause;

    int errors = 0;
    int checks = 0;

    reset_sequencer #(
        .STRETCH_CYCLES(SC),
        .STAGE_GAP(SG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .soft_rst_req(soft_rst_req),
        .mem_init_done(mem_init_done),
        .periph_rst(periph_rst),
        .mem_rst(mem_rst),
        .cpu_rst(cpu_rst),
        .rst_done(rst_done),
        .rst_cause(rst_cause)
    );

    always #5 clk = ~clk;

    // Reference model: time since release and release timestamps.
    bit         m_hold = 1'b1;
    int         m_t = 0;
    int         m_periph_at = 0;
    int         m_mem_at = 0;
    bit         m_running = 1'b0;
    logic [1:0] m_cause = 2'b01;

    function automatic logic [5:0] model_out();
        logic [5:0] o;
        if (m_hold) begin
            o = {1'b1, 1'b1, 1'b1, 1'b0, m_cause};
        end else begin
            o = {logic'(m_t < m_periph_at), logic'(m_t < m_mem_at),
                 logic'(!m_running), logic'(m_running), m_cause};
        end
        return o;
    endfunction

    task automatic model_edge(input bit r, input bit req, input bit mid);
        if (r) begin
            m_hold = 1'b1;
            m_running = 1'b0;
            m_cause = 2'b01;
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_t = 0;
            m_periph_at = SC;
            m_mem_at = SC + SG;
            m_running = 1'b0;
        end else begin
            if (m_running && req) begin
                m_running = 1'b0;
                m_mem_at = m_t + 1 + SG;
                m_cause = 2'b10;
            end else if (!m_running && m_t >= m_mem_at && mid) begin
                m_running = 1'b1;
            end
            m_t = m_t + 1;
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {periph_rst, mem_rst, cpu_rst, rst_done, rst_cause};
    endfunction

    task automatic check(input string name, input logic [5:0] act,
                         input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (periph,mem,cpu,done,cause)",
                     name, act, exp);
        end
    endtask

    task automatic check_order();
        logic ok;
        ok = (!cpu_rst -> !mem_rst) && (!mem_rst -> !periph_rst);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL order: got p=%b m=%b c=%b required cpu->mem->periph",
                     periph_rst, mem_rst, cpu_rst);
        end
    endtask

    // One clock edge with given inputs, checked against the model.
    task automatic step(input string name, input bit r, input bit req,
                        input bit mid);
        rst = r;
        soft_rst_req = req;
        mem_init_done = mid;
        @(posedge clk);
        #1;
        model_edge(r, req, mid);
        check(name, dut_out(), model_out());
        check_order();
    endtask

    typedef struct {
        bit         r;
        bit         req;
        bit         mid;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit req, input bit mid,
                       input logic [5:0] exp);
        vec_t v;
        v.r = r;
        v.req = req;
        v.mid = mid;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        // Scenario 1 then 3: power-up with mem ready, then soft pulse.
        add(1, 0, 1, 6'b111_0_01);
        add(0, 0, 1, 6'b111_0_01);
        add(0, 0, 1, 6'b111_0_01);
        add(0, 0, 1, 6'b111_0_01);
        add(0, 0, 1, 6'b111_0_01);
        add(0, 0, 1, 6'b011_0_01);
        add(0, 0, 1, 6'b011_0_01);
        add(0, 0, 1, 6'b001_0_01);
        add(0, 0, 1, 6'b000_1_01);
        add(0, 0, 1, 6'b000_1_01);
        add(0, 1, 1, 6'b011_0_10);
        add(0, 0, 1, 6'b011_0_10);
        add(0, 0, 1, 6'b001_0_10);
        add(0, 0, 1, 6'b000_1_10);
        add(0, 0, 1, 6'b000_1_10);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r;
            soft_rst_req = vecs[i].req;
            mem_init_done = vecs[i].mid;
            @(posedge clk);
            #1;
            model_edge(vecs[i].r, vecs[i].req, vecs[i].mid);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Scenario 2: memory preload completes late.
        step("s2_rst", 1, 0, 0);
        for (int i = 0; i < SC + SG + 10; i++)
            step("s2_wait", 0, 0, 0);
        check("s2_cpu_held", dut_out(), 6'b001_0_01);
        step("s2_release", 0, 0, 1);
        check("s2_released", dut_out(), 6'b000_1_01);

        // Scenario 4: reset reasserted in PGAP, then a clean restart.
        step("s4_rst", 1, 0, 1);
        for (int i = 0; i < 5; i++)
            step("s4_pre", 0, 0, 1);
        step("s4_reassert", 1, 0, 1);
        check("s4_all_held", dut_out(), 6'b111_0_01);
        for (int i = 0; i < SC + SG + 3; i++)
            step("s4_restart", 0, 0, 1);
        check("s4_run", dut_out(), 6'b000_1_01);

        // Scenario 5: request held high; rst wins over it in RUN.
        step("s5_rst", 1, 1, 1);
        for (int i = 0; i < 30; i++)
            step("s5_held", 0, 1, 1);
        for (int i = 0; i < 10 && !m_running; i++)
            step("s5_settle", 0, 0, 1);
        check("s5_in_run", dut_out(), 6'b000_1_10);
        step("s5_both", 1, 1, 1);
        check("s5_rst_wins", dut_out(), 6'b111_0_01);
        step("s5_t0", 0, 0, 1);
        check("s5_from_hold", dut_out(), 6'b111_0_01);

        // Scenario 6: preload pulse before WAIT_MEM is ignored.
        step("s6_rst", 1, 0, 0);
        step("s6_t0", 0, 0, 0);
        step("s6_pulse", 0, 0, 1);
        for (int i = 0; i < SC + SG; i++)
            step("s6_pgap", 0, 0, (i == SC) ? 1'b1 : 1'b0);
        for (int i = 0; i < 40; i++)
            step("s6_stuck", 0, 0, 0);
        check("s6_waiting", dut_out(), 6'b001_0_01);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
